imem_loader: RTL and testbench

Host-side program loader and run controller for the single-cycle core. It accepts a stream of 9-bit machine-code words over a valid/ready handshake and writes them sequentially into instruction memory from address 0. It then releases the core's `start` (PC reset) and counts execution cycles until the core raises `done`. It is the writer/launcher for the instruction memory and program counter that the core reads from.

---
 rtl/imem_loader_if.sv | 33 +++
 rtl/imem_loader.sv | 107 ++++++++++
 tb/tb_imem_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Word-stream handshake and instruction-memory write bus between the host-side
// loader and its neighbours.
interface imem_loader_if #(
  parameter int D = 12,
  parameter int W = 9
);
  logic [W-1:0] in_word;
  logic         in_valid;
  logic         in_ready;
  logic         imem_wr_en;
  logic [D-1:0] imem_addr;
  logic [W-1:0] imem_data;

  // Host side: supplies words and observes the memory writes.
  modport master (
    output in_word,
    output in_valid,
    input  in_ready,
    input  imem_wr_en,
    input  imem_addr,
    input  imem_data
  );

  // Loader side: accepts words and drives the memory writes.
  modport slave (
    input  in_word,
    input  in_valid,
    output in_ready,
    output imem_wr_en,
    output imem_addr,
    output imem_data
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader and run controller: streams words into instruction memory
// from address 0, releases the core, then counts cycles until the core is done.
module imem_loader #(
  parameter int D         = 12,
  parameter int W         = 9,
  parameter int START_CYC = 2,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_go,
  input  logic [D-1:0]  load_len,
  imem_loader_if.slave  bus,
  output logic          core_start,
  input  logic          core_done,
  output logic          busy,
  output logic          run_done,
  output logic [CW-1:0] run_cycles
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam int SW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [SW-1:0] START_LAST = SW'(START_CYC - 1);

  logic [1:0]    state;
  logic [D-1:0]  len_q;
  logic [D-1:0]  word_cnt;
  logic [SW-1:0] start_cnt;
  logic          accept;
  logic          last_word;

  assign bus.in_ready = (state == S_LOAD);
  assign busy         = (state != S_IDLE);
  assign accept       = (state == S_LOAD) && bus.in_valid;
  assign last_word    = (word_cnt == (len_q - 1'b1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      len_q          <= '0;
      word_cnt       <= '0;
      start_cnt      <= '0;
      bus.imem_wr_en <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_data  <= '0;
      core_start     <= 1'b1;
      run_done       <= 1'b0;
      run_cycles     <= '0;
    end else begin
      bus.imem_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          core_start <= 1'b1;
          if (load_go) begin
            len_q      <= load_len;
            word_cnt   <= '0;
            start_cnt  <= '0;
            run_cycles <= '0;
            run_done   <= 1'b0;
            state      <= (load_len == '0) ? S_START : S_LOAD;
          end
        end

        S_LOAD: begin
          if (accept) begin
            bus.imem_wr_en <= 1'b1;
            bus.imem_addr  <= word_cnt;
            bus.imem_data  <= bus.in_word;
            word_cnt       <= word_cnt + 1'b1;
            if (last_word) begin
              start_cnt <= '0;
              state     <= S_START;
            end
          end
        end

        S_START: begin
          // The final write lands in the first START cycle, so the core is
          // released only after instruction memory is complete.
          if (start_cnt == START_LAST) begin
            core_start <= 1'b0;
            state      <= S_RUN;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (core_done) begin
            run_done   <= 1'b1;
            core_start <= 1'b1;
            state      <= S_IDLE;
          end else if (run_cycles != '1) begin
            run_cycles <= run_cycles + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboarded writes plus run-control timing.
module tb_imem_loader;

  localparam int D  = 12;
  localparam int W  = 9;
  localparam int CW = 4;

  typedef struct packed {
    logic [D-1:0] a;
    logic [W-1:0] d;
  } wr_t;

  logic          clk;
  logic          reset_n;
  logic          load_go;
  logic [D-1:0]  load_len;
  logic          core_start;
  logic          core_done;
  logic          busy;
  logic          run_done;
  logic [CW-1:0] run_cycles;

  int  errors;
  int  checks;
  wr_t exp_q[$];

  imem_loader_if #(.D(D), .W(W)) bus ();

  imem_loader #(.D(D), .W(W), .START_CYC(2), .CW(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_go    (load_go),
    .load_len   (load_len),
    .bus        (bus.slave),
    .core_start (core_start),
    .core_done  (core_done),
    .busy       (busy),
    .run_done   (run_done),
    .run_cycles (run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.imem_wr_en !== 1'b0 || bus.imem_addr !== '0 ||
        bus.imem_data !== '0 || core_start !== 1'b1 || busy !== 1'b0 ||
        run_done !== 1'b0 || run_cycles !== '0) begin
      errors++;
      $display("FAIL reset_vals: got rdy=%b wr=%b addr=%h data=%h cs=%b busy=%b rd=%b rc=%0d want 0,0,0,0,1,0,0,0",
               bus.in_ready, bus.imem_wr_en, bus.imem_addr, bus.imem_data, core_start, busy,
               run_done, run_cycles);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    // start a load, then pulse reset mid-cycle
    load_go = 1'b1; load_len = 12'd3;
    step();
    load_go = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL go_accept: got busy=%b rdy=%b want 1,1", busy, bus.in_ready);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0 || core_start !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got busy=%b rdy=%b cs=%b want 0,0,1", busy, bus.in_ready, core_start);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic_load;
    logic [W-1:0] words [3];
    logic [D-1:0] addr_n;
    logic         acc;
    wr_t          e;
    words[0] = 9'h1A3; words[1] = 9'h005; words[2] = 9'h1FF;
    addr_n = '0;
    load_go = 1'b1; load_len = 12'd3;
    step();
    load_go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_word  = words[i];
      acc = (addr_n < 12'd3);
      if (acc) begin
        exp_q.push_back({addr_n, words[i]});
        addr_n++;
      end
      step();
      checks++;
      e = exp_q.pop_front();
      if (bus.imem_wr_en !== 1'b1 || bus.imem_addr !== e.a || bus.imem_data !== e.d) begin
        errors++;
        $display("FAIL basic_write%0d: got en=%b addr=%h data=%h want en=1 addr=%h data=%h",
                 i, bus.imem_wr_en, bus.imem_addr, bus.imem_data, e.a, e.d);
      end
    end
    // keep in_valid high: must be ignored in START
    bus.in_word = 9'h0F0;
    step();
    checks++;
    if (core_start !== 1'b1 || busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.imem_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_start1: got cs=%b busy=%b rdy=%b wr=%b want 1,1,0,0",
               core_start, busy, bus.in_ready, bus.imem_wr_en);
    end
    bus.in_valid = 1'b0;
    core_done = 1'b0;
    step();
    checks++;
    if (core_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: got cs=%b busy=%b want 0,1", core_start, busy);
    end
  endtask

  // Entered in the first RUN cycle after test_basic_load.
  task automatic test_run_timing;
    for (int i = 0; i < 10; i++) begin
      core_done = 1'b0;
      load_go   = (i == 4);
      load_len  = 12'd5;
      step();
      load_go = 1'b0;
      if (i == 4) begin
        checks++;
        if (run_cycles !== 4'd5 || busy !== 1'b1 || bus.in_ready !== 1'b0 || core_start !== 1'b0) begin
          errors++;
          $display("FAIL run_mid: got rc=%0d busy=%b rdy=%b cs=%b want 5,1,0,0",
                   run_cycles, busy, bus.in_ready, core_start);
        end
      end
    end
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    checks++;
    if (run_cycles !== 4'd10 || run_done !== 1'b1 || busy !== 1'b0 || core_start !== 1'b1) begin
      errors++;
      $display("FAIL run_done: got rc=%0d rd=%b busy=%b cs=%b want 10,1,0,1",
               run_cycles, run_done, busy, core_start);
    end
  endtask

  // Also exercises back-to-back: load_go on the edge right after done.
  task automatic test_empty_load;
    load_go = 1'b1; load_len = 12'd0;
    bus.in_valid = 1'b1; bus.in_word = 9'h155;
    step();
    load_go = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0 || core_start !== 1'b1 || bus.imem_wr_en !== 1'b0 ||
        run_done !== 1'b0 || run_cycles !== '0) begin
      errors++;
      $display("FAIL empty_start: got busy=%b rdy=%b cs=%b wr=%b rd=%b rc=%0d want 1,0,1,0,0,0",
               busy, bus.in_ready, core_start, bus.imem_wr_en, run_done, run_cycles);
    end
    step();
    checks++;
    if (core_start !== 1'b1 || bus.imem_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL empty_start2: got cs=%b wr=%b want 1,0", core_start, bus.imem_wr_en);
    end
    bus.in_valid = 1'b0;
    core_done = 1'b1;
    step();
    checks++;
    if (core_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL empty_run: got cs=%b busy=%b want 0,1", core_start, busy);
    end
    step();
    core_done = 1'b0;
    checks++;
    if (run_cycles !== '0 || run_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_done: got rc=%0d rd=%b busy=%b want 0,1,0", run_cycles, run_done, busy);
    end
  endtask

  task automatic test_gaps;
    logic [6:0]   pat;
    logic [D-1:0] addr_n;
    logic         acc;
    logic [W-1:0] w;
    wr_t          e;
    pat = 7'b1011001;
    addr_n = '0;
    load_go = 1'b1; load_len = 12'd4;
    step();
    load_go = 1'b0;
    for (int i = 0; i < 7; i++) begin
      w = 9'h100 + W'(i * 7);
      bus.in_valid = pat[i];
      bus.in_word  = w;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL gap_ready%0d: got %b want 1", i, bus.in_ready);
      end
      acc = pat[i] && (addr_n < 12'd4);
      if (acc) begin
        exp_q.push_back({addr_n, w});
        addr_n++;
      end
      step();
      checks++;
      if (acc) begin
        e = exp_q.pop_front();
        if (bus.imem_wr_en !== 1'b1 || bus.imem_addr !== e.a || bus.imem_data !== e.d) begin
          errors++;
          $display("FAIL gap_write%0d: got en=%b addr=%h data=%h want en=1 addr=%h data=%h",
                   i, bus.imem_wr_en, bus.imem_addr, bus.imem_data, e.a, e.d);
        end
      end else if (bus.imem_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL gap_idle%0d: got en=%b want 0", i, bus.imem_wr_en);
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL gap_end: got rdy=%b pending=%0d want 0,0", bus.in_ready, exp_q.size());
    end
    core_done = 1'b1;
    step(); step(); step();
    core_done = 1'b0;
    checks++;
    if (run_done !== 1'b1 || busy !== 1'b0 || run_cycles !== '0) begin
      errors++;
      $display("FAIL gap_run: got rd=%b busy=%b rc=%0d want 1,0,0", run_done, busy, run_cycles);
    end
  endtask

  task automatic test_saturate;
    load_go = 1'b1; load_len = 12'd0;
    step();
    load_go = 1'b0;
    core_done = 1'b0;
    step(); step();
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 14) begin
        checks++;
        if (run_cycles !== 4'd15) begin
          errors++;
          $display("FAIL sat_reach: got rc=%0d want 15", run_cycles);
        end
      end
    end
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    checks++;
    if (run_cycles !== 4'd15 || run_done !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: got rc=%0d rd=%b want 15,1", run_cycles, run_done);
    end
  endtask

  task automatic test_reset_mid_load;
    logic [D-1:0] addr_n;
    wr_t          e;
    addr_n = '0;
    load_go = 1'b1; load_len = 12'd5;
    step();
    load_go = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_word  = 9'h0C0 + W'(i);
      exp_q.push_back({addr_n, bus.in_word});
      addr_n++;
      step();
      checks++;
      e = exp_q.pop_front();
      if (bus.imem_wr_en !== 1'b1 || bus.imem_addr !== e.a || bus.imem_data !== e.d) begin
        errors++;
        $display("FAIL rml_write%0d: got en=%b addr=%h data=%h want en=1 addr=%h data=%h",
                 i, bus.imem_wr_en, bus.imem_addr, bus.imem_data, e.a, e.d);
      end
    end
    bus.in_valid = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.imem_wr_en !== 1'b0 || bus.imem_addr !== '0 ||
        bus.imem_data !== '0 || core_start !== 1'b1 || run_done !== 1'b0 || run_cycles !== '0) begin
      errors++;
      $display("FAIL rml_reset: got busy=%b rdy=%b wr=%b addr=%h data=%h cs=%b rd=%b rc=%0d want 0,0,0,0,0,1,0,0",
               busy, bus.in_ready, bus.imem_wr_en, bus.imem_addr, bus.imem_data, core_start,
               run_done, run_cycles);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    load_go = 1'b1; load_len = 12'd1;
    step();
    load_go = 1'b0;
    bus.in_valid = 1'b1; bus.in_word = 9'h0AA;
    exp_q.push_back({12'd0, 9'h0AA});
    step();
    bus.in_valid = 1'b0;
    checks++;
    e = exp_q.pop_front();
    if (bus.imem_wr_en !== 1'b1 || bus.imem_addr !== e.a || bus.imem_data !== e.d) begin
      errors++;
      $display("FAIL rml_reload: got en=%b addr=%h data=%h want en=1 addr=%h data=%h",
               bus.imem_wr_en, bus.imem_addr, bus.imem_data, e.a, e.d);
    end
    core_done = 1'b0;
    step(); step();
    for (int i = 0; i < 3; i++) step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    checks++;
    if (run_cycles !== 4'd3 || run_done !== 1'b1 || busy !== 1'b0 || core_start !== 1'b1) begin
      errors++;
      $display("FAIL rml_run: got rc=%0d rd=%b busy=%b cs=%b want 3,1,0,1",
               run_cycles, run_done, busy, core_start);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    load_go = 1'b0;
    load_len = '0;
    core_done = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_word = '0;
    test_reset();
    test_basic_load();
    test_run_timing();
    test_empty_load();
    test_gaps();
    test_saturate();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
